// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types: FSM encoding, default reset PC
// and the 64-bit prefetch entry layout {pc, instr}.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: push/pop/flush, head on dout, count/full/empty.
// Pointers carry an extra MSB so full and empty differ.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: fetch PC, one-outstanding imem requests, prefetch
// FIFO to decode, redirect flush. FETCH_PERF_EN adds perf counters.
module instr_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pc_plus4,
`ifdef FETCH_PERF_EN
  output logic [31:0]            perf_flush_cnt,
  output logic [31:0]            perf_stall_cnt,
`endif
  output logic [$clog2(DEPTH):0] count
);

  fetch_state_e state, state_nx;
  logic [31:0]  fetch_pc, fetch_pc_nx;
  fetch_entry_t head, wr_entry;
  logic         full, empty;
  logic         push, pop;
  logic         req_fire, rsp_in;

  assign out_valid = reset && !empty && !redirect_valid;
  assign pop       = out_valid && out_ready;

  assign imem_req_valid = reset && (state == REQ)
                        && (!full || pop);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_in    = imem_rsp_valid
                   && (state == WAIT || state == DISCARD);
  assign push      = rsp_in && (state == WAIT)
                   && !redirect_valid;

  // fetch_pc already advanced past the outstanding request
  assign wr_entry  = '{pc: fetch_pc - 32'd4,
                       instr: imem_rsp_data};
  assign imem_addr = fetch_pc;

  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = head.pc + 32'd4;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_nx = redirect_pc & ~32'h3;
      // a response still owed must be thrown away; one that
      // lands in this very cycle settles the old request
      if (req_fire || (state != REQ && !rsp_in))
        state_nx = DISCARD;
      else
        state_nx = REQ;
    end else begin
      unique case (state)
        REQ: begin
          if (req_fire) begin
            state_nx    = WAIT;
            fetch_pc_nx = fetch_pc + 32'd4;
          end
        end
        WAIT, DISCARD: begin
          if (rsp_in) state_nx = REQ;
        end
        default: state_nx = REQ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_entry),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (redirect_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (out_ready && !out_valid && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised + directed bench for instr_fetch_queue against
// a queue-based model of the fetch stage.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic [2:0]  count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_flush_cnt, perf_stall_cnt;
`endif

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
`ifdef FETCH_PERF_EN
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .count          (count)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // stimulus knobs
  int rdy_pct, ordy_pct, dmin, dmax;
  bit noise;

  // memory side
  bit mem_pend, rsp_from_mem;
  int mem_dly;

  // model
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] m_pc, m_req_pc;
  bit          m_out, m_drop;
  logic [31:0] m_flush, m_stall;

  // event logs for literal checks
  logic [31:0] acc_addr[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_p4[$];
  int          pop_cyc[$];
  int          cyc_n;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               n, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] qat(logic [31:0] q[$],
                                      int i);
    return (q.size() > i) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic model_clear();
    mq_pc.delete(); mq_in.delete();
    m_pc = 32'h0; m_req_pc = '0;
    m_out = 0; m_drop = 0;
    m_flush = '0; m_stall = '0;
    mem_pend = 0; mem_dly = 0;
    acc_addr.delete(); pop_pc.delete();
    pop_p4.delete(); pop_cyc.delete();
  endtask

  // called at negedge: compare, then advance model and logs
  task automatic step();
    bit ev, pop, er, fire, rsp;
    int room;
    ev   = (mq_pc.size() != 0) && !redirect_valid;
    pop  = ev && out_ready;
    room = DEPTH - (mq_pc.size() - int'(pop));
    er   = !m_out && room >= 1;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("req_valid", 32'(imem_req_valid), 32'(er));
    chk("imem_addr", imem_addr, m_pc);
    chk("count", 32'(count), 32'(mq_pc.size()));
    if (ev) begin
      chk("out_pc", out_pc, mq_pc[0]);
      chk("out_instr", out_instr, mq_in[0]);
      chk("out_pc_plus4", out_pc_plus4, mq_pc[0] + 32'd4);
    end
`ifdef FETCH_PERF_EN
    chk("perf_flush", perf_flush_cnt, m_flush);
    chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    fire = er && imem_req_ready;
    rsp  = m_out && imem_rsp_valid;
    if (redirect_valid) m_flush++;
    if (out_ready && !ev) m_stall++;
    if (redirect_valid) begin
      mq_pc.delete(); mq_in.delete();
      m_pc = redirect_pc & ~32'h3;
      if (fire) begin m_out = 1; m_drop = 1; end
      else if (rsp) begin m_out = 0; m_drop = 0; end
      else if (m_out) m_drop = 1;
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (rsp) begin
        if (!m_drop) begin
          mq_pc.push_back(m_req_pc);
          mq_in.push_back(imem_rsp_data);
        end
        m_out = 0; m_drop = 0;
      end
      if (fire) begin
        m_out = 1; m_drop = 0;
        m_req_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
    if (rsp_from_mem) mem_pend = 0;
    if (imem_req_valid && imem_req_ready) begin
      mem_pend = 1;
      mem_dly  = $urandom_range(dmax, dmin);
      acc_addr.push_back(imem_addr);
    end
    if (out_valid && out_ready) begin
      pop_pc.push_back(out_pc);
      pop_p4.push_back(out_pc_plus4);
      pop_cyc.push_back(cyc_n);
    end
    cyc_n++;
  endtask

  // one clock cycle; entered and left at posedge+1
  task automatic cyc(input bit rd, input logic [31:0] tgt);
    redirect_valid = rd;
    redirect_pc    = tgt;
    imem_req_ready = ($urandom_range(100, 1) <= rdy_pct);
    out_ready      = ($urandom_range(100, 1) <= ordy_pct);
    rsp_from_mem   = 0;
    imem_rsp_data  = $urandom;
    if (mem_pend && mem_dly == 0) begin
      imem_rsp_valid = 1;
      rsp_from_mem   = 1;
    end else begin
      if (mem_pend) mem_dly--;
      imem_rsp_valid = noise && !mem_pend
                     && ($urandom_range(7, 0) == 0);
    end
    @(negedge clock);
    step();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  task automatic cfg(input int r, input int o,
                     input int lo, input int hi);
    rdy_pct = r; ordy_pct = o; dmin = lo; dmax = hi;
    noise = 0;
  endtask

  task automatic reset_checks();
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_flush", perf_flush_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
  endtask

  task automatic do_reset();
    reset = 0;
    redirect_valid = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; out_ready = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset_checks();
    reset = 1;
  endtask

  initial begin
    cyc_n = 0;
    cfg(100, 100, 0, 0);

    // 1: streaming fetch, one word per two cycles
    do_reset();
    run(8);
    chk("t1_addr0", qat(acc_addr, 0), 32'h0);
    chk("t1_addr1", qat(acc_addr, 1), 32'h4);
    chk("t1_addr2", qat(acc_addr, 2), 32'h8);
    chk("t1_pc0", qat(pop_pc, 0), 32'h0);
    chk("t1_pc1", qat(pop_pc, 1), 32'h4);
    chk("t1_pc2", qat(pop_pc, 2), 32'h8);
    chk("t1_p4_0", qat(pop_p4, 0), 32'h4);
    chk("t1_p4_1", qat(pop_p4, 1), 32'h8);
    chk("t1_p4_2", qat(pop_p4, 2), 32'hC);
    chk("t1_rate", (pop_cyc.size() > 1)
        ? 32'(pop_cyc[1] - pop_cyc[0]) : 32'hx, 32'd2);

    // 2: decode stalled fills the FIFO
    do_reset();
    cfg(100, 0, 0, 0);
    run(12);
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_req_valid", 32'(imem_req_valid), 32'h0);
    cfg(100, 100, 0, 0);
    run(4);
    chk("t2_next_addr", qat(acc_addr, 4), 32'h10);

    // 3: redirect while waiting for memory
    do_reset();
    cfg(100, 100, 3, 3);
    cyc(1'b0, '0);
    cyc(1'b1, 32'h0000_0103);
    chk("t3_count", 32'(count), 32'h0);
    run(12);
    chk("t3_addr", qat(acc_addr, 1), 32'h100);
    chk("t3_pc", qat(pop_pc, 0), 32'h100);

    // 4: redirect + response + decode handshake together
    do_reset();
    cfg(100, 0, 0, 0);
    run(3);
    ordy_pct = 100;
    cyc(1'b1, 32'h0000_0040);
    chk("t4_count", 32'(count), 32'h0);
    chk("t4_no_pop", 32'(pop_pc.size()), 32'h0);
    run(6);
    chk("t4_addr", qat(acc_addr, 2), 32'h40);

    // 5: PC wrap at the top of the address space
    do_reset();
    cfg(100, 100, 0, 0);
    cyc(1'b1, 32'hFFFF_FFFE);
    run(8);
    chk("t5_addr_top", qat(acc_addr, 1), 32'hFFFF_FFFC);
    chk("t5_addr_wrap", qat(acc_addr, 2), 32'h0);
    chk("t5_pc_top", qat(pop_pc, 0), 32'hFFFF_FFFC);
    chk("t5_p4_top", qat(pop_p4, 0), 32'h0);
    chk("t5_p4_wrap", qat(pop_p4, 1), 32'h4);

    // random traffic
    do_reset();
    cfg(70, 60, 0, 3);
    noise = 1;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(19, 0) == 0, $urandom);

    // 6: reset asserted while a request is outstanding
    cfg(100, 100, 2, 2);
    for (int i = 0; i < 50 && !(m_out && mem_dly > 0); i++)
      run(1);
    chk("t6_in_wait", 32'(m_out), 32'h1);
    reset = 0;
    #1;
    reset_checks();
    do_reset();
    cfg(100, 100, 0, 0);
    run(3);
    chk("t6_first_addr", qat(acc_addr, 0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
